// File: rtl/invsqrt_seq.sv
// invsqrt_seq: 1/sqrt(x) on IEEE-754 singles, magic-constant seed refined by ITER Newton-Raphson steps
// Latency: 2 + ITER*(3*Lm + La + 8) cycles with an always-ready multiplier/adder of latency Lm/La
// Backpressure: requests held until rdy; result held in DONE until out_ready; in_ready only in IDLE
// Optional build macro INVSQRT_SEQ_ERR_CHECK_EN: negative, zero, inf/NaN and denormal operands
// bypass the iteration and return quiet NaN with err_out set.
module invsqrt_seq #(
   parameter int          ITER  = 2,
   parameter logic [31:0] MAGIC = 32'h5F3759DF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] x_in,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] y_out,
   output logic        err_out,
   output logic        mul_req,
   output logic [31:0] mul_a,
   output logic [31:0] mul_b,
   input  logic        mul_rdy,
   input  logic [31:0] mul_res,
   input  logic        mul_res_vld,
   input  logic        mul_err,
   output logic        add_req,
   output logic [31:0] add_a,
   output logic [31:0] add_b,
   input  logic        add_rdy,
   input  logic [31:0] add_res,
   input  logic        add_res_vld
);

   localparam logic [31:0] ONE_HALF_3 = 32'h3FC00000;  // 1.5
   localparam logic [31:0] QNAN       = 32'h7FC00000;
   localparam logic [2:0]  ITER_C     = 3'(ITER);

   typedef enum logic [2:0] {IDLE, SEED, MYY, MXH, SUB, MY, DONE} state_t;
   // Each arithmetic state walks REQ -> WAIT -> COMMIT; COMMIT is a settle cycle so
   // every operation costs its unit latency plus two cycles.
   typedef enum logic [1:0] {PH_REQ, PH_WAIT, PH_COMMIT} phase_t;

   state_t      state, state_nxt;
   phase_t      ph, ph_nxt;
   logic [31:0] x_r, xh_r, y_r, t_r;
   logic        err_r;
   logic [2:0]  cnt_r;
   logic        ld_x, ld_seed, ld_bad, cap, cnt_inc;

`ifdef INVSQRT_SEQ_ERR_CHECK_EN
   logic x_bad;
   assign x_bad = x_r[31] | (x_r[30:23] == 8'h00) | (x_r[30:23] == 8'hFF);
`endif

   // State and phase registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         ph    <= PH_REQ;
      end else begin
         state <= state_nxt;
         ph    <= ph_nxt;
      end
   end

   // Next-state, handshake outputs and operand muxing
   always_comb begin
      state_nxt = state;
      ph_nxt    = ph;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      y_out     = 32'h0;
      err_out   = 1'b0;
      mul_req   = 1'b0;
      mul_a     = 32'h0;
      mul_b     = 32'h0;
      add_req   = 1'b0;
      add_a     = 32'h0;
      add_b     = 32'h0;
      ld_x      = 1'b0;
      ld_seed   = 1'b0;
      ld_bad    = 1'b0;
      cap       = 1'b0;
      cnt_inc   = 1'b0;
      case (state)
         IDLE: begin
            in_ready = ~rst;
            if (in_valid) begin
               ld_x      = 1'b1;
               state_nxt = SEED;
            end
         end
         SEED: begin
`ifdef INVSQRT_SEQ_ERR_CHECK_EN
            if (x_bad) begin
               ld_bad    = 1'b1;
               state_nxt = DONE;
            end else begin
               ld_seed   = 1'b1;
               state_nxt = MYY;
            end
`else
            ld_seed   = 1'b1;
            state_nxt = MYY;
`endif
         end
         MYY, MXH, SUB, MY: begin
            case (ph)
               PH_REQ: begin
                  if (state == SUB) begin
                     add_req = 1'b1;
                     add_a   = ONE_HALF_3;
                     add_b   = {~t_r[31], t_r[30:0]};
                     if (add_rdy) ph_nxt = PH_WAIT;
                  end else begin
                     mul_req = 1'b1;
                     case (state)
                        MYY:     begin mul_a = y_r; mul_b = y_r;  end
                        MXH:     begin mul_a = t_r; mul_b = xh_r; end
                        default: begin mul_a = y_r; mul_b = t_r;  end
                     endcase
                     if (mul_rdy) ph_nxt = PH_WAIT;
                  end
               end
               PH_WAIT: begin
                  if ((state == SUB) ? add_res_vld : mul_res_vld) begin
                     cap    = 1'b1;
                     ph_nxt = PH_COMMIT;
                  end
               end
               default: begin
                  ph_nxt = PH_REQ;
                  case (state)
                     MYY:     state_nxt = MXH;
                     MXH:     state_nxt = SUB;
                     SUB:     state_nxt = MY;
                     default: begin
                        cnt_inc   = 1'b1;
                        state_nxt = (cnt_r + 3'd1 == ITER_C) ? DONE : MYY;
                     end
                  endcase
               end
            endcase
         end
         DONE: begin
            out_valid = 1'b1;
            y_out     = y_r;
            err_out   = err_r;
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Operand, seed, intermediate and error registers
   always_ff @(posedge clk) begin
      if (rst) begin
         x_r   <= 32'h0;
         xh_r  <= 32'h0;
         y_r   <= 32'h0;
         t_r   <= 32'h0;
         err_r <= 1'b0;
         cnt_r <= 3'd0;
      end else begin
         if (ld_x) begin
            x_r   <= x_in;
            xh_r  <= {x_in[31], x_in[30:23] - 8'd1, x_in[22:0]};
            err_r <= 1'b0;
            cnt_r <= 3'd0;
         end
         if (ld_seed) y_r <= MAGIC - (x_r >> 1);
         if (ld_bad) begin
            y_r   <= QNAN;
            err_r <= 1'b1;
         end
         if (cap) begin
            if (state == SUB)     t_r <= add_res;
            else if (state == MY) y_r <= mul_res;
            else                  t_r <= mul_res;
            if (state != SUB && mul_err) err_r <= 1'b1;
         end
         if (cnt_inc) cnt_r <= cnt_r + 3'd1;
      end
   end

endmodule
